// File: rtl/fpu_req_issuer_if.sv
// FPU operation caller bus: operand/mode request side and result/exception return side.
// Four-phase valid/valid handshake: the master raises Data_valid with stable operands,
// the FPU answers with Dataout_valid, the master drops Data_valid, and the FPU drops
// Dataout_valid before the next request may be raised.
interface fpu_req_issuer_if;
  logic [31:0] Datain1;
  logic [31:0] Datain2;
  logic [2:0]  Mode;
  logic        Data_valid;
  logic [31:0] Dataout;
  logic        Dataout_valid;
  logic [2:0]  Exc;

  modport master (
    output Datain1, Datain2, Mode, Data_valid,
    input  Dataout, Dataout_valid, Exc
  );

  modport slave (
    input  Datain1, Datain2, Mode, Data_valid,
    output Dataout, Dataout_valid, Exc
  );
endinterface

// File: rtl/fpu_req_issuer.sv
// Buffers host operand pairs in a small FIFO and issues them one at a time to the FPU,
// returning each result (or a watchdog timeout) as a single-cycle strobe.
module fpu_req_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [31:0]             Op_datain1,
  input  logic [31:0]             Op_datain2,
  input  logic [2:0]              Op_mode,
  input  logic                    Op_push,
  output logic                    Op_full,
  fpu_req_issuer_if.master        fpu,
  output logic [31:0]             Res_data,
  output logic [2:0]              Res_exc,
  output logic                    Res_timeout,
  output logic                    Res_valid,
  output logic                    Busy,
  output logic [1:0]              dbg_state
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 67;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REQ      = 2'd1;
  localparam logic [1:0] S_WAIT_LOW = 2'd2;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [31:0]   din1_q, din1_d, din2_q, din2_d;
  logic [2:0]    mode_q, mode_d;
  logic          dv_q, dv_d;
  logic [31:0]   res_data_q, res_data_d;
  logic [2:0]    res_exc_q, res_exc_d;
  logic          res_to_q, res_to_d;
  logic          res_valid_q, res_valid_d;
  logic          push_ok, pop;

  assign push_ok = Op_push && (count_q != CW'(DEPTH));

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    din1_d      = din1_q;
    din2_d      = din2_q;
    mode_d      = mode_q;
    dv_d        = dv_q;
    res_data_d  = res_data_q;
    res_exc_d   = res_exc_q;
    res_to_d    = res_to_q;
    res_valid_d = 1'b0;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A stale Dataout_valid from the previous exchange blocks a new issue.
        if (count_q != '0 && !fpu.Dataout_valid) begin
          pop                      = 1'b1;
          {din1_d, din2_d, mode_d} = mem_q[rptr_q];
          dv_d                     = 1'b1;
          wd_d                     = '0;
          state_d                  = S_REQ;
        end
      end
      S_REQ: begin
        wd_d = wd_q + 1'b1;
        if (fpu.Dataout_valid) begin
          res_data_d  = fpu.Dataout;
          res_exc_d   = fpu.Exc;
          res_to_d    = 1'b0;
          res_valid_d = 1'b1;
          dv_d        = 1'b0;
          state_d     = S_WAIT_LOW;
        end else if (TIMEOUT != 0 && wd_q == WD_LAST) begin
          res_data_d  = '0;
          res_exc_d   = '0;
          res_to_d    = 1'b1;
          res_valid_d = 1'b1;
          dv_d        = 1'b0;
          state_d     = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        if (!fpu.Dataout_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wptr_q] <= {Op_datain1, Op_datain2, Op_mode};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      wd_q        <= '0;
      din1_q      <= '0;
      din2_q      <= '0;
      mode_q      <= '0;
      dv_q        <= 1'b0;
      res_data_q  <= '0;
      res_exc_q   <= '0;
      res_to_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      wd_q        <= wd_d;
      din1_q      <= din1_d;
      din2_q      <= din2_d;
      mode_q      <= mode_d;
      dv_q        <= dv_d;
      res_data_q  <= res_data_d;
      res_exc_q   <= res_exc_d;
      res_to_q    <= res_to_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign fpu.Datain1    = din1_q;
  assign fpu.Datain2    = din2_q;
  assign fpu.Mode       = mode_q;
  assign fpu.Data_valid = dv_q;
  assign Res_data       = res_data_q;
  assign Res_exc        = res_exc_q;
  assign Res_timeout    = res_to_q;
  assign Res_valid      = res_valid_q;
  assign Op_full        = (count_q == CW'(DEPTH));
  assign Busy           = (count_q != '0) || (state_q != S_IDLE);
  assign dbg_state      = state_q;
endmodule
